decode_execute_unit: RTL and testbench



---
 rtl/decode_execute_unit.sv | 174 +++++++++++++++++
 tb/tb_decode_execute_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_unit.sv
// Decode/execute slice of the 16-bit monocycle core: control decoder, 8x16 register file,
// sign extension, ALU and branch/jump target generation. The register file is the only state.
module decode_execute_unit #(
    parameter bit R0_HARDWIRED = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] instruction,
    input  logic [15:0] PC4,
    input  logic [15:0] dataToWrite,
    output logic        RegDst,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        Jump,
    output logic [1:0]  ALUOp,
    output logic [15:0] readData1,
    output logic [15:0] readData2,
    output logic [15:0] extendedSignal,
    output logic [15:0] outputALU,
    output logic        Zero,
    output logic [15:0] outputBranch,
    output logic        PCSrc,
    output logic [15:0] jumpAddress
);

    typedef enum logic [3:0] {
        OP_RTYPE = 4'b0000,
        OP_LW    = 4'b0001,
        OP_SW    = 4'b0010,
        OP_BEQ   = 4'b0011,
        OP_ADDI  = 4'b0100,
        OP_J     = 4'b0101
    } opcode_e;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_SUB = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_XOR = 3'b100,
        FN_SLT = 3'b101,
        FN_SLL = 3'b110,
        FN_SRL = 3'b111
    } funct_e;

    logic [3:0]  opcode;
    logic [2:0]  rs, rt, rd, funct;
    logic [5:0]  imm6;
    logic [11:0] jtarget;

    assign opcode  = instruction[15:12];
    assign rs      = instruction[11:9];
    assign rt      = instruction[8:6];
    assign rd      = instruction[5:3];
    assign funct   = instruction[2:0];
    assign imm6    = instruction[5:0];
    assign jtarget = instruction[11:0];

    // Control decoder
    always_comb begin
        RegDst   = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemtoReg = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        Jump     = 1'b0;
        ALUOp    = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                ALUOp    = 2'b10;
            end
            OP_LW: begin
                ALUSrc   = 1'b1;
                MemRead  = 1'b1;
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            OP_SW: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            OP_BEQ: begin
                Branch = 1'b1;
                ALUOp  = 2'b01;
            end
            OP_ADDI: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
            end
            OP_J: begin
                Jump = 1'b1;
            end
            default: ;
        endcase
    end

    // Register file: asynchronous reads, write on the rising edge
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [2:0]  waddr;
    logic        wr_en;

    assign waddr = RegDst ? rd : rt;
    assign wr_en = RegWrite && !(R0_HARDWIRED && (waddr == 3'd0));

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[waddr] = dataToWrite;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign readData1 = (R0_HARDWIRED && (rs == 3'd0)) ? 16'h0000 : regs_q[rs];
    assign readData2 = (R0_HARDWIRED && (rt == 3'd0)) ? 16'h0000 : regs_q[rt];

    assign extendedSignal = {{10{imm6[5]}}, imm6};

    // ALU
    logic [15:0] alu_a, alu_b;

    assign alu_a = readData1;
    assign alu_b = ALUSrc ? extendedSignal : readData2;

    always_comb begin
        outputALU = alu_a + alu_b;
        case (ALUOp)
            2'b01: outputALU = alu_a - alu_b;
            2'b10: begin
                case (funct)
                    FN_ADD: outputALU = alu_a + alu_b;
                    FN_SUB: outputALU = alu_a - alu_b;
                    FN_AND: outputALU = alu_a & alu_b;
                    FN_OR:  outputALU = alu_a | alu_b;
                    FN_XOR: outputALU = alu_a ^ alu_b;
                    FN_SLT: outputALU = {15'd0, ($signed(alu_a) < $signed(alu_b))};
                    FN_SLL: outputALU = alu_a << alu_b[3:0];
                    FN_SRL: outputALU = alu_a >> alu_b[3:0];
                    default: outputALU = alu_a + alu_b;
                endcase
            end
            default: outputALU = alu_a + alu_b;
        endcase
    end

    assign Zero = (outputALU == 16'h0000);

    // Branch/jump targets; sums wrap mod 2^16
    assign outputBranch = PC4 + {extendedSignal[14:0], 1'b0};
    assign PCSrc        = Branch & Zero;
    assign jumpAddress  = {PC4[15:13], jtarget, 1'b0};

endmodule

// File: tb/tb_decode_execute_unit.sv
// Randomized self-checking bench for decode_execute_unit against a behavioural model,
// with directed cases pinning the model to hand-computed values.
module tb_decode_execute_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] instruction, PC4, dataToWrite;
    logic        RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump;
    logic [1:0]  ALUOp;
    logic [15:0] readData1, readData2, extendedSignal, outputALU, outputBranch, jumpAddress;
    logic        Zero, PCSrc;

    int tests = 0;
    int fails = 0;

    decode_execute_unit #(.R0_HARDWIRED(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .instruction(instruction), .PC4(PC4),
        .dataToWrite(dataToWrite), .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .Jump(Jump), .ALUOp(ALUOp), .readData1(readData1), .readData2(readData2),
        .extendedSignal(extendedSignal), .outputALU(outputALU), .Zero(Zero),
        .outputBranch(outputBranch), .PCSrc(PCSrc), .jumpAddress(jumpAddress)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    logic [15:0] mregs [8];

    typedef struct {
        logic [9:0]  ctrl;   // {RegDst,Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,Jump,ALUOp}
        logic [15:0] rd1, rd2, ext, alu, br, jaddr;
        logic        zero, pcsrc;
        logic [2:0]  waddr;
    } exp_t;

    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] pc4);
        exp_t e;
        int unsigned op = ins[15:12];
        int signed   sa, sb, imm;
        logic [15:0] a, b;
        logic [2:0]  fn = ins[2:0];
        case (op)
            0: e.ctrl = 10'b1000001010;
            1: e.ctrl = 10'b0011011000;
            2: e.ctrl = 10'b0000110000;
            3: e.ctrl = 10'b0100000001;
            4: e.ctrl = 10'b0000011000;
            5: e.ctrl = 10'b0000000100;
            default: e.ctrl = 10'b0;
        endcase
        e.rd1 = (ins[11:9] == 0) ? 16'h0 : mregs[ins[11:9]];
        e.rd2 = (ins[8:6] == 0) ? 16'h0 : mregs[ins[8:6]];
        imm = (ins[5:0] >= 32) ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
        e.ext = 16'(imm);
        a = e.rd1;
        b = (op == 1 || op == 2 || op == 4) ? e.ext : e.rd2;
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        if (op == 3)
            e.alu = 16'(int'(a) - int'(b));
        else if (op == 0)
            case (fn)
                1: e.alu = 16'(int'(a) - int'(b));
                2: e.alu = a & b;
                3: e.alu = a | b;
                4: e.alu = a ^ b;
                5: e.alu = (sa < sb) ? 16'd1 : 16'd0;
                6: e.alu = 16'(int'(a) * (1 << (b % 16)));
                7: e.alu = 16'(int'(a) / (1 << (b % 16)));
                default: e.alu = 16'(int'(a) + int'(b));
            endcase
        else
            e.alu = 16'(int'(a) + int'(b));
        e.zero  = (e.alu == 0);
        e.pcsrc = (op == 3) && e.zero;
        e.br    = 16'(int'(pc4) + 2 * imm);
        e.jaddr = 16'((pc4 / 16'h2000) * 16'h2000 + 2 * (ins % 16'h1000));
        e.waddr = (op == 0) ? ins[5:3] : ins[8:6];
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (instr %h PC4 %h)", name, act, exp, instruction, PC4);
        end
    endtask

    // Drive inputs, then at the falling edge compare every output against the model
    task automatic apply(input logic [15:0] ins, input logic [15:0] pc4, input logic [15:0] dw,
                         input logic rst_n);
        exp_t e;
        instruction = ins;
        PC4         = pc4;
        dataToWrite = dw;
        reset_n     = rst_n;
        @(negedge clock);
        e = model(ins, pc4);
        chk("ctrl", 16'({RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, ALUOp}),
            16'(e.ctrl));
        chk("readData1", readData1, e.rd1);
        chk("readData2", readData2, e.rd2);
        chk("extendedSignal", extendedSignal, e.ext);
        chk("outputALU", outputALU, e.alu);
        chk("Zero", 16'(Zero), 16'(e.zero));
        chk("outputBranch", outputBranch, e.br);
        chk("PCSrc", 16'(PCSrc), 16'(e.pcsrc));
        chk("jumpAddress", jumpAddress, e.jaddr);
    endtask

    // Rising edge: update the model register file
    task automatic tick();
        exp_t e;
        e = model(instruction, PC4);
        @(posedge clock);
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        end else if (e.ctrl[3] && e.waddr != 0) begin
            mregs[e.waddr] = dataToWrite;
        end
        #1;
    endtask

    initial begin
        instruction = 16'hF000;
        PC4         = 16'h0;
        dataToWrite = 16'h0;
        reset_n     = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 16'hXXXX;
        @(posedge clock);
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        #1;

        // Every register reads zero after reset
        for (int r = 0; r < 8; r++) begin
            logic [15:0] ins;
            ins = 16'hF000 | 16'(r << 9) | 16'(r << 6);
            apply(ins, 16'h0, 16'h1234, 1'b1);
            chk("reset_rd1", readData1, 16'h0000);
            chk("reset_rd2", readData2, 16'h0000);
            tick();
        end

        // ADDI r1,r0,#-3
        apply(16'h407D, 16'h0100, 16'hFFFD, 1'b1);
        chk("addi_alu", outputALU, 16'hFFFD);
        chk("addi_regwrite", 16'(RegWrite), 16'h1);
        tick();
        apply(16'hF200, 16'h0, 16'h0, 1'b1);
        chk("reg1", readData1, 16'hFFFD);
        tick();
        // r2 = 2, then slt r3 = r1 < r2 signed
        apply(16'h4082, 16'h0, 16'h0002, 1'b1);
        tick();
        apply(16'h029D, 16'h0, 16'h0001, 1'b1);
        chk("slt", outputALU, 16'h0001);
        tick();
        // r2 = 0x8000, r4 = 4, srl r5 = r2 >> 4
        apply(16'h0010, 16'h0, 16'h8000, 1'b1);
        tick();
        apply(16'h4104, 16'h0, 16'h0004, 1'b1);
        tick();
        apply(16'h052F, 16'h0, 16'h0800, 1'b1);
        chk("srl", outputALU, 16'h0800);
        tick();
        // r3 = 4; BEQ r3,r4 taken, BEQ r3,r2 not taken
        apply(16'h40C4, 16'h0, 16'h0004, 1'b1);
        tick();
        apply(16'h3702, 16'h0010, 16'h0, 1'b1);
        chk("beq_zero", 16'(Zero), 16'h1);
        chk("beq_pcsrc", 16'(PCSrc), 16'h1);
        chk("beq_target", outputBranch, 16'h0014);
        tick();
        apply(16'h3682, 16'h0010, 16'h0, 1'b1);
        chk("bne_pcsrc", 16'(PCSrc), 16'h0);
        tick();
        // J
        apply(16'h5123, 16'hE000, 16'h0, 1'b1);
        chk("j_jump", 16'(Jump), 16'h1);
        chk("j_addr", jumpAddress, 16'hE246);
        chk("j_nowrite", 16'({RegWrite, MemWrite}), 16'h0);
        tick();
        // Write to r0 is dropped; opcode 1111 is a NOP
        apply(16'h0240, 16'h0, 16'hBEEF, 1'b1);
        tick();
        apply(16'hF000, 16'h0, 16'h0, 1'b1);
        chk("r0_hardwired", readData1, 16'h0000);
        chk("nop_ctrl", 16'({RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, ALUOp}),
            16'h0);
        tick();
        // Same-cycle write/read returns the old value
        apply(16'h4241, 16'h0, 16'h5555, 1'b1);
        chk("no_bypass", readData1, 16'hFFFD);
        tick();
        // Reset blocks a pending write
        apply(16'h407D, 16'h0, 16'h7777, 1'b0);
        tick();
        apply(16'hF240, 16'h0, 16'h0, 1'b1);
        chk("reset_blocks_write", readData1, 16'h0000);
        tick();

        // Randomized traffic, opcodes biased toward the defined ones
        for (int n = 0; n < 600; n++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ins[15:12] = 4'($urandom_range(0, 5));
            apply(ins, 16'($urandom), 16'($urandom), ($urandom_range(0, 40) != 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
